// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and receiver.
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;
endpackage

// File: rtl/uart_transmitter_s_if.sv
// Bus-side signals of the UART transmitter.
interface uart_transmitter_s_if
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [UART_DATA_BITS-1:0] TX_DATA;
    logic                      TX_EN;
    logic                      TX_STATUS;
    logic                      TX_BUSY;
    logic                      TX_DONE;
    logic [CW-1:0]             FIFO_COUNT;
    logic                      UART_TX;

    modport master (
        output TX_DATA, TX_EN,
        input  TX_STATUS, TX_BUSY, TX_DONE, FIFO_COUNT, UART_TX
    );
    modport slave (
        input  TX_DATA, TX_EN,
        output TX_STATUS, TX_BUSY, TX_DONE, FIFO_COUNT, UART_TX
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO; DEPTH must be a power of two so the pointers wrap on their own.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     BRclk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_data = mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge BRclk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge BRclk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/uart_transmitter_s.sv
// UART 8N1/8N2 transmitter: FIFO-buffered, LSB first, back-to-back frames.
//   state | meaning
//   IDLE  | line high, waiting for a queued byte
//   START | start bit (low) for OVERSAMPLE cycles
//   DATA  | data bits, shift[0] on the line
//   STOP  | stop bit(s) high; pops the next byte on the last cycle
module uart_transmitter_s
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  BRclk,
    input  logic                  reset,
    uart_transmitter_s_if.slave   bus
);
    localparam int BW = $clog2(OVERSAMPLE);
    localparam int PW = $clog2(UART_DATA_BITS);

    uart_state_t               state, state_n;
    logic [BW-1:0]             bitcnt, bitcnt_n;
    logic [PW-1:0]             pos, pos_n;
    logic [UART_DATA_BITS-1:0] shift, shift_n;
    logic                      tx_q, tx_n;
    logic                      pop;
    logic                      bit_end;
    logic                      last_stop;
    logic [UART_DATA_BITS-1:0] rd_data;
    logic                      full;
    logic                      empty;
    logic [$clog2(FIFO_DEPTH):0] count;

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(UART_DATA_BITS)) u_fifo (
        .BRclk   (BRclk),
        .reset   (reset),
        .push    (bus.TX_EN),
        .pop     (pop),
        .wr_data (bus.TX_DATA),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    assign bit_end   = (bitcnt == BW'(OVERSAMPLE - 1));
    assign last_stop = (state == STOP) && bit_end && (pos == PW'(STOP_BITS - 1));

    always_comb begin
        state_n  = state;
        bitcnt_n = bitcnt;
        pos_n    = pos;
        shift_n  = shift;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    shift_n  = rd_data;
                    state_n  = START;
                    bitcnt_n = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n  = DATA;
                    bitcnt_n = '0;
                    pos_n    = '0;
                end else begin
                    bitcnt_n = bitcnt + BW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    bitcnt_n = '0;
                    shift_n  = shift >> 1;
                    if (pos == PW'(UART_DATA_BITS - 1)) begin
                        state_n = STOP;
                        pos_n   = '0;
                    end else begin
                        pos_n = pos + PW'(1);
                    end
                end else begin
                    bitcnt_n = bitcnt + BW'(1);
                end
            end
            STOP: begin
                if (last_stop) begin
                    bitcnt_n = '0;
                    pos_n    = '0;
                    // Chain straight into the next start bit when data is waiting.
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_n = rd_data;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end else if (bit_end) begin
                    bitcnt_n = '0;
                    pos_n    = pos + PW'(1);
                end else begin
                    bitcnt_n = bitcnt + BW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
        tx_n = (state_n == START) ? 1'b0 :
               (state_n == DATA)  ? shift_n[0] : 1'b1;
    end

    always_ff @(posedge BRclk) begin
        if (!reset) begin
            state  <= IDLE;
            bitcnt <= '0;
            pos    <= '0;
            shift  <= '0;
            tx_q   <= 1'b1;
        end else begin
            state  <= state_n;
            bitcnt <= bitcnt_n;
            pos    <= pos_n;
            shift  <= shift_n;
            tx_q   <= tx_n;
        end
    end

    assign bus.UART_TX    = tx_q;
    assign bus.TX_DONE    = last_stop;
    assign bus.TX_BUSY    = (state != IDLE) | ~empty;
    assign bus.TX_STATUS  = ~full;
    assign bus.FIFO_COUNT = count;
endmodule

// File: tb/tb_uart_transmitter_s.sv
// Bench for uart_transmitter_s: directed timing steps plus a random phase,
// line content recovered by decoding the recorded UART_TX waveform.
module tb_uart_transmitter_s;
    localparam int OS   = 16;
    localparam int MAXC = 16384;

    logic BRclk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   edge_n = 0;

    bit   h_tx   [2][MAXC];
    bit   h_done [2][MAXC];
    logic [7:0] dec_bytes[$];
    int         dec_start[$];

    always #5 BRclk = ~BRclk;

    uart_transmitter_s_if #(.FIFO_DEPTH(4)) b1 ();
    uart_transmitter_s_if #(.FIFO_DEPTH(4)) b2 ();

    uart_transmitter_s #(.OVERSAMPLE(16), .STOP_BITS(1), .FIFO_DEPTH(4)) dut1 (
        .BRclk (BRclk), .reset (reset), .bus (b1));
    uart_transmitter_s #(.OVERSAMPLE(16), .STOP_BITS(2), .FIFO_DEPTH(4)) dut2 (
        .BRclk (BRclk), .reset (reset), .bus (b2));

    always @(posedge BRclk) edge_n <= edge_n + 1;

    // Index e holds the line state following rising edge number e.
    always @(negedge BRclk) begin
        if (edge_n < MAXC) begin
            h_tx[0][edge_n]   <= b1.UART_TX;
            h_done[0][edge_n] <= b1.TX_DONE;
            h_tx[1][edge_n]   <= b2.UART_TX;
            h_done[1][edge_n] <= b2.TX_DONE;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge BRclk);
        #1;
        if (edge_n >= MAXC - 2) begin
            $display("FAIL cycle_budget observed=%0d expected<%0d", edge_n, MAXC - 2);
            $fatal(1);
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic wr(input int w, input logic [7:0] d);
        if (w == 0) begin b1.TX_DATA = d; b1.TX_EN = 1'b1; end
        else        begin b2.TX_DATA = d; b2.TX_EN = 1'b1; end
        tick();
        b1.TX_EN = 1'b0;
        b2.TX_EN = 1'b0;
    endtask

    // Recover frames from the recorded line: start low, 8 stable bits, stop high,
    // TX_DONE only on the final stop cycle. Every violation bumps bad.
    task automatic decode(input int w, input int from, input int to, input int ns, output int bad);
        int i;
        int s;
        int len;
        logic [7:0] b;
        dec_bytes.delete();
        dec_start.delete();
        bad = 0;
        len = OS * (9 + ns);
        i = from;
        while (i < to) begin
            if (h_tx[w][i] == 1'b0) begin
                s = i;
                if (s + len > to) begin
                    bad++;
                    break;
                end
                for (int k = 0; k < OS; k++) if (h_tx[w][s + k] != 1'b0) bad++;
                for (int k = 0; k < 8; k++) begin
                    b[k] = h_tx[w][s + OS * (k + 1) + OS / 2];
                    for (int j = 0; j < OS; j++)
                        if (h_tx[w][s + OS * (k + 1) + j] != b[k]) bad++;
                end
                for (int j = OS * 9; j < len; j++) if (h_tx[w][s + j] != 1'b1) bad++;
                for (int j = 0; j < len; j++)
                    if (h_done[w][s + j] != (j == len - 1)) bad++;
                dec_bytes.push_back(b);
                dec_start.push_back(s);
                i = s + len;
            end else begin
                if (h_done[w][i]) bad++;
                i++;
            end
        end
    endtask

    initial begin
        int n0, s0, bad, cnt, free_at, e, ndone;
        bit en, pushed, popped;
        logic [7:0] d;
        logic [7:0] burst [4];
        logic [7:0] ov [5];
        logic [7:0] exp_q[$];

        reset = 1'b0;
        b1.TX_EN = 1'b0; b1.TX_DATA = '0;
        b2.TX_EN = 1'b0; b2.TX_DATA = '0;
        run(3);
        chk("rst_tx", b1.UART_TX, 1);
        chk("rst_status", b1.TX_STATUS, 1);
        chk("rst_busy", b1.TX_BUSY, 0);
        chk("rst_count", b1.FIFO_COUNT, 0);
        chk("rst_done", b1.TX_DONE, 0);
        chk("rst_tx2", b2.UART_TX, 1);
        reset = 1'b1;
        run(2);

        // Single byte: latency, start edge, TX_DONE position, BUSY release.
        wr(0, 8'hA3);
        n0 = edge_n;
        chk("t1_count_n", b1.FIFO_COUNT, 1);
        chk("t1_tx_n", b1.UART_TX, 1);
        chk("t1_busy_n", b1.TX_BUSY, 1);
        tick();
        chk("t1_count_n1", b1.FIFO_COUNT, 0);
        chk("t1_tx_n1", b1.UART_TX, 0);
        run(158);
        chk("t1_done_early", b1.TX_DONE, 0);
        tick();
        chk("t1_done_n160", b1.TX_DONE, 1);
        chk("t1_busy_n160", b1.TX_BUSY, 1);
        tick();
        chk("t1_done_after", b1.TX_DONE, 0);
        chk("t1_busy_after", b1.TX_BUSY, 0);
        chk("t1_tx_after", b1.UART_TX, 1);
        run(5);
        decode(0, n0, edge_n, 1, bad);
        chk("t1_frames", dec_bytes.size(), 1);
        if (dec_bytes.size() == 1) begin
            chk("t1_byte", dec_bytes[0], 8'hA3);
            chk("t1_start", dec_start[0], n0 + 1);
        end
        chk("t1_bad", bad, 0);

        // Burst of four on consecutive edges.
        burst[0] = 8'h55; burst[1] = 8'h0F; burst[2] = 8'hFF; burst[3] = 8'h00;
        n0 = edge_n + 1;
        for (int k = 0; k < 4; k++) begin
            wr(0, burst[k]);
            chk("t2_status", b1.TX_STATUS, 1);
        end
        run(660);
        decode(0, n0, edge_n, 1, bad);
        chk("t2_frames", dec_bytes.size(), 4);
        for (int k = 0; k < 4 && k < dec_bytes.size(); k++) begin
            chk("t2_byte", dec_bytes[k], burst[k]);
            chk("t2_start", dec_start[k], n0 + 1 + 160 * k);
        end
        ndone = 0;
        for (int i = n0; i < edge_n; i++) if (h_done[0][i]) ndone++;
        chk("t2_done_pulses", ndone, 4);
        chk("t2_bad", bad, 0);

        // Overflow: one in flight, then five writes into a depth-4 FIFO.
        n0 = edge_n + 1;
        wr(0, 8'h11);
        run(2);
        for (int k = 0; k < 5; k++) begin
            ov[k] = 8'($urandom_range(0, 255));
            wr(0, ov[k]);
            chk("t3_status", b1.TX_STATUS, (k < 3) ? 1 : 0);
            chk("t3_count", b1.FIFO_COUNT, (k < 3) ? k + 1 : 4);
        end
        run(5 * 160 + 20);
        decode(0, n0, edge_n, 1, bad);
        chk("t3_frames", dec_bytes.size(), 5);
        if (dec_bytes.size() == 5) begin
            chk("t3_byte0", dec_bytes[0], 8'h11);
            for (int k = 0; k < 4; k++) chk("t3_byte", dec_bytes[k + 1], ov[k]);
        end
        chk("t3_bad", bad, 0);

        // Reset during data bit 3 of 0xA3 with another byte queued.
        d = 8'hA3;
        wr(0, d);
        s0 = edge_n + 1;
        wr(0, 8'h5A);
        run(s0 + 70 - edge_n);
        chk("t4_bit3", b1.UART_TX, d[3]);
        reset = 1'b0;
        tick();
        chk("t4_rst_tx", b1.UART_TX, 1);
        chk("t4_rst_count", b1.FIFO_COUNT, 0);
        chk("t4_rst_busy", b1.TX_BUSY, 0);
        chk("t4_rst_status", b1.TX_STATUS, 1);
        reset = 1'b1;
        tick();
        n0 = edge_n;
        run(200);
        decode(0, n0, edge_n, 1, bad);
        chk("t4_no_frames", dec_bytes.size(), 0);
        chk("t4_idle_bad", bad, 0);
        n0 = edge_n + 1;
        wr(0, 8'h3C);
        run(170);
        decode(0, n0, edge_n, 1, bad);
        chk("t4_frames", dec_bytes.size(), 1);
        if (dec_bytes.size() == 1) begin
            chk("t4_byte", dec_bytes[0], 8'h3C);
            chk("t4_start", dec_start[0], n0 + 1);
        end
        chk("t4_bad", bad, 0);

        // Two stop bits: 176-cycle frames.
        n0 = edge_n + 1;
        wr(1, 8'h80);
        wr(1, 8'hC5);
        run(2 * 176 + 10);
        decode(1, n0, edge_n, 2, bad);
        chk("t5_frames", dec_bytes.size(), 2);
        if (dec_bytes.size() == 2) begin
            chk("t5_byte0", dec_bytes[0], 8'h80);
            chk("t5_byte1", dec_bytes[1], 8'hC5);
            chk("t5_start0", dec_start[0], n0 + 1);
            chk("t5_gap", dec_start[1] - dec_start[0], 176);
        end
        chk("t5_bad", bad, 0);
        chk("t5_done_at_176", h_done[1][n0 + 176], 1);

        // Random writes against an occupancy/line-time model.
        run(5);
        cnt = 0;
        free_at = 0;
        exp_q.delete();
        n0 = edge_n + 1;
        for (int c = 0; c < 1500; c++) begin
            en = ($urandom_range(0, 99) < (((c / 250) % 2 == 1) ? 4 : 60));
            d  = 8'($urandom_range(0, 255));
            b1.TX_EN = en;
            b1.TX_DATA = d;
            tick();
            e = edge_n;
            popped = (cnt > 0) && (e >= free_at);
            pushed = en && (cnt < 4);
            if (pushed) exp_q.push_back(d);
            if (popped) free_at = e + 160;
            cnt = cnt + int'(pushed) - int'(popped);
            chk("rnd_count", b1.FIFO_COUNT, cnt);
            chk("rnd_status", b1.TX_STATUS, cnt < 4);
            chk("rnd_busy", b1.TX_BUSY, (cnt != 0) || (e < free_at));
        end
        b1.TX_EN = 1'b0;
        run(5 * 160 + 40);
        decode(0, n0, edge_n, 1, bad);
        chk("rnd_frames", dec_bytes.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < dec_bytes.size(); k++)
            chk("rnd_byte", dec_bytes[k], exp_q[k]);
        chk("rnd_bad", bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_transmitter_s.md
# uart_transmitter_s

UART 8N1/8N2 serial transmitter: the transmit-side counterpart of the team's UART receiver, running on the same 16x baud-rate clock. It buffers bytes from the CPU/peripheral bus in a small FIFO and serializes them LSB-first onto `UART_TX`. Frames go out back-to-back while data is queued.

## Interface
Parameters:
- `OVERSAMPLE`, 16: BRclk cycles per bit. Must match the receiver's oversampling.
- `STOP_BITS`, 1: number of stop bits (1 or 2).
- `FIFO_DEPTH`, 4: transmit FIFO entries. Must be a power of two, ≥2.

Ports:
- `BRclk` in 1: 16x baud clock. This is the only clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-low reset (0 = reset), sampled on the `BRclk` rising edge.
- `TX_DATA` in 8: byte to send. Sampled when `TX_EN`=1.
- `TX_EN` in 1: write strobe, 1 cycle per byte.
- `TX_STATUS` out 1: 1 when FIFO not full (write accepted).
- `TX_BUSY` out 1: 1 while a frame is on the line or the FIFO is non-empty.
- `TX_DONE` out 1: 1-cycle pulse at the end of each frame's last stop bit.
- `FIFO_COUNT` out log2(FIFO_DEPTH)+1: entries queued.
- `UART_TX` out 1: serial line, idle high.

## Operation
- Reset values (`reset`=0 at an edge): `UART_TX`=1, `TX_STATUS`=1, `TX_BUSY`=0, `TX_DONE`=0, `FIFO_COUNT`=0. On reset the FSM goes to IDLE and the FIFO pointers clear.
- Reset mid-frame aborts the frame. The line returns high on that edge; no partial stop bit is sent; queued data is discarded.
- Push: at an edge with `TX_EN`=1 and `TX_STATUS`=1, `TX_DATA` is written to the FIFO.
  - `TX_EN` while full is ignored (byte dropped, count unchanged, no error flag).
- Pop and push in the same cycle (count < DEPTH): both occur and the count is unchanged.
- FSM states: IDLE, START, DATA, STOP. Counters are `bitcnt` (0..OVERSAMPLE-1) and `pos` (0..7 in DATA, 0..STOP_BITS-1 in STOP).
  - IDLE: `UART_TX`=1. If the FIFO is non-empty, pop into the shift register → START, `bitcnt`=0.
  - START: `UART_TX`=0 for OVERSAMPLE cycles → DATA, `pos`=0.
  - DATA: `UART_TX`=shift[0] for OVERSAMPLE cycles per bit, shift right after each bit. After bit 7 → STOP.
  - STOP: `UART_TX`=1 for OVERSAMPLE×STOP_BITS cycles. On the final cycle, `TX_DONE`=1. If the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise → IDLE.
- `UART_TX` is driven from a flop (glitch-free).
- `TX_BUSY` = (state≠IDLE) | (count≠0).

## Timing
- Write latency: write at edge N to an empty FIFO in IDLE.
  - Edge N+1: pop; `UART_TX` falls (start bit begins).
  - `FIFO_COUNT` is 1 after N and 0 after N+1.
- Frame length: OVERSAMPLE×(9+STOP_BITS) cycles, which is 160 cycles for the defaults.
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop-bit cycle.
- Data bit k occupies cycles [16(k+1), 16(k+2)) after the start-bit edge (default OVERSAMPLE).
- `TX_STATUS` updates on the same edge the count changes. It is not combinationally dependent on `TX_EN`.
- `TX_DONE` is high for exactly one cycle per frame, coincident with the last stop-bit cycle.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum (IDLE/START/DATA/STOP)
  - `UART_OVERSAMPLE`=16
  - `UART_DATA_BITS`=8

  The receiver uses the same package.
- Sub-module `uart_tx_fifo` is a synchronous FIFO, parameterized by depth and width. It has push/pop/full/empty/count and the same clock and reset.
- The top level holds the FSM, counters, shift register and output flops.

## Test plan
- Reset: hold `reset`=0 for 3 cycles → `UART_TX`=1, `TX_STATUS`=1, `TX_BUSY`=0, `FIFO_COUNT`=0.
- Single byte 0xA3: write at edge N → `UART_TX` low from N+1 for 16 cycles.
  - Data bits 1,1,0,0,0,1,0,1 follow, 16 cycles each, then high for 16 cycles.
  - `TX_DONE` pulses at cycle N+160; `TX_BUSY` falls after it.
- Burst: write 0x55, 0x0F, 0xFF, 0x00 on 4 consecutive cycles.
  - `TX_STATUS` stays 1 (the first pop frees a slot).
  - The 4 frames go out with no idle gap: 640 cycles total and 4 `TX_DONE` pulses.
- Overflow: with the line busy, write 5 bytes while FIFO_DEPTH=4 and no pop → `TX_STATUS`=0 after the 4th write.
  - The 5th byte is dropped.
  - Only 4 frames are transmitted, plus the one already in flight.
- Reset mid-frame: assert `reset`=0 during data bit 3 of 0xA3.
  - `UART_TX`=1 on that edge, `FIFO_COUNT`=0.
  - Bytes written after release transmit normally.
- STOP_BITS=2: send 0x80 → stop level high for 32 cycles, frame length 176 cycles. A loopback into the receiver yields RX_DATA=0x80.
